ahb_img_mem: RTL and testbench
==============================

// Module: ahb_img_mem
// PURPOSE
//  AHB slave image memory with single-master grant logic; sits directly downstream of the rotation DMA.
//  Serves the DMA's HBUSREQ/HGRANT handshake, accepts its address/data-phase transfers, and returns
//  HRDATA/HREADY. Holds the source image and receives the rotated image.
//  Bench and FPGA target for the rotation top.
// PARAMETERS
//  DEPTH        4096          number of 32-bit words; power of two
//  BASE         32'h0000_0000 byte address of word 0; aligned to 4*DEPTH
//  WAIT_CYCLES  1             wait states inserted per OKAY data phase (0..15)
// PORTS
//  I_MEM_HCLK     in   1   the one clock
//  I_MEM_HRESET_N in   1   reset; asynchronous assert, active-low
//  I_MEM_HBUSREQ  in   1   bus request from DMA
//  I_MEM_HADDR    in   32  byte address (address phase)
//  I_MEM_HTRANS   in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  I_MEM_HSIZE    in   3   000 byte, 001 half, 010 word
//  I_MEM_HBURST   in   3   ignored for decode; every beat is handled individually
//  I_MEM_HWRITE   in   1   1 = write
//  I_MEM_HWDATA   in   32  write data (data phase)
//  O_MEM_HGRANT   out  1   bus grant
//  O_MEM_HREADY   out  1   transfer done / slave ready
//  O_MEM_HRESP    out  2   00 OKAY, 01 ERROR
//  O_MEM_HRDATA   out  32  read data; valid when HREADY=1 in the last cycle of a read data phase, else 0
//  O_MEM_WR_CNT   out  16  completed OKAY write beats; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset values: HGRANT=0, HREADY=1, HRESP=00, HRDATA=0, WR_CNT=0, state=IDLE.
//   Memory array is not reset.
//  Grant: HGRANT <= HBUSREQ every cycle.
//   Asserts 1 cycle after HBUSREQ rises and drops 1 cycle after it falls.
//  Address phase accepted when HREADY=1 and HTRANS[1]=1.
//   Captures addr, write, size into data-phase registers.
//   IDLE/BUSY: no transfer; zero-wait OKAY.
//  States: IDLE, WAIT, LAST, ERR1, ERR2.
//   IDLE: accept -> WAIT if WAIT_CYCLES>0, else LAST. Bad access -> ERR1.
//   WAIT: HREADY=0, HRESP=00; counts WAIT_CYCLES cycles, then -> LAST.
//   LAST: HREADY=1, HRESP=00.
//     Write: HWDATA sampled this cycle and byte lanes committed at this edge.
//     Read: HRDATA = mem[word] combinationally.
//     A new accept in this cycle re-enters WAIT/LAST/ERR1 (pipelined, no idle gap); otherwise -> IDLE.
//   ERR1: HREADY=0, HRESP=01 -> ERR2.
//   ERR2: HREADY=1, HRESP=01; write suppressed. Accept in this cycle is handled as in LAST.
//  Address/control inputs are ignored while HREADY=0; the master holds them.
//  Word index = (HADDR-BASE)>>2, taken modulo DEPTH.
//  Byte lanes are little-endian, selected by HADDR[1:0] and HSIZE.
//   byte: lane HADDR[1:0]; half: lanes {HADDR[1],0}+{1,0}; word: all four lanes.
//   Read returns the full word regardless of size.
//  Back-to-back write then read to the same word returns the new data.
//   The write commits before the read data phase.
//  WR_CNT increments at the LAST-cycle edge of each OKAY write.
//  Reset mid-transfer: the transfer is aborted, all outputs return to reset values, and a
//   partially waited write is never committed.
// CONFIGURATION
//  AHB_MEM_ERR_EN defined:
//   - Any of these gives the ERR1/ERR2 two-cycle ERROR response: address outside
//     [BASE, BASE+4*DEPTH-1], misaligned access (half with HADDR[0]=1, word with
//     HADDR[1:0]!=0), or HSIZE>010.
//   - No memory change, no WR_CNT increment, HRDATA=0.
//  Undefined:
//   - ERR states are unreachable and HRESP is tied to 00.
//   - Out-of-range addresses wrap modulo DEPTH.
//   - Misaligned low bits are forced to 0 for half/word; HSIZE>010 is treated as word.
// TESTING
//  1 Grant: HBUSREQ 0->1 at cycle 5 -> HGRANT=1 at cycle 6; HBUSREQ 1->0 at 20 -> HGRANT=0 at 21.
//  2 Word write then read, WAIT_CYCLES=1:
//    NONSEQ write 0x10 with 0xDEADBEEF, then NONSEQ read 0x10.
//    Each data phase shows HREADY=0 for 1 cycle then 1; HRDATA=0xDEADBEEF; WR_CNT=1.
//  3 Byte lanes: word 0x20 preloaded 0x00000000.
//    Byte write 0xAA to 0x21, then half write 0x1234 to 0x22 (HWDATA=0x12340000).
//    Read 0x20 -> 0x1234AA00.
//  4 Pipelined 4-beat burst, WAIT_CYCLES=0:
//    NONSEQ+3 SEQ writes 0x40..0x4C with 1,2,3,4.
//    HREADY stays 1 throughout; reads return 1,2,3,4; WR_CNT=4.
//  5 AHB_MEM_ERR_EN defined: write to BASE+4*DEPTH.
//    -> HREADY 0,1 with HRESP=01 both cycles; WR_CNT unchanged.
//    Without the macro, the same write lands in word 0.
//  6 Reset: assert I_MEM_HRESET_N low during the WAIT of a write to 0x80 (old 0x5).
//    -> HREADY=1, HGRANT=0, HRESP=00 immediately; after release, read 0x80 = 0x5.

Source files
------------

// File: rtl/ahb_img_mem.sv
// AHB slave image memory with single-master grant, programmable wait states and byte-lane writes.
// Optional ERROR responses for out-of-range, misaligned or oversize accesses: define AHB_MEM_ERR_EN.
module ahb_img_mem #(
  parameter int          DEPTH       = 4096,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        I_MEM_HCLK,
  input  logic        I_MEM_HRESET_N,
  input  logic        I_MEM_HBUSREQ,
  input  logic [31:0] I_MEM_HADDR,
  input  logic [1:0]  I_MEM_HTRANS,
  input  logic [2:0]  I_MEM_HSIZE,
  input  logic [2:0]  I_MEM_HBURST,
  input  logic        I_MEM_HWRITE,
  input  logic [31:0] I_MEM_HWDATA,
  output logic        O_MEM_HGRANT,
  output logic        O_MEM_HREADY,
  output logic [1:0]  O_MEM_HRESP,
  output logic [31:0] O_MEM_HRDATA,
  output logic [15:0] O_MEM_WR_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_wait_cnt;
  logic            r_grant;
  logic [15:0]     r_wr_cnt;
  logic [AW-1:0]   r_word;
  logic [1:0]      r_lane;
  logic [2:0]      r_size;
  logic            r_write;
  logic [31:0]     r_mem [DEPTH];

  logic [31:0]     w_off;
  logic            w_accept;
  logic            w_bad;
  logic [3:0]      w_be;
  logic [31:0]     w_mask;
  logic [31:0]     w_wmerged;
  logic            w_we;

  assign w_off    = I_MEM_HADDR - BASE;
  assign w_accept = O_MEM_HREADY & I_MEM_HTRANS[1];

`ifdef AHB_MEM_ERR_EN
  assign w_bad = (w_off[31:AW+2] != '0)
               | ((I_MEM_HSIZE == 3'b001) & I_MEM_HADDR[0])
               | ((I_MEM_HSIZE == 3'b010) & (I_MEM_HADDR[1:0] != 2'b00))
               | (I_MEM_HSIZE > 3'b010);
  logic w_unused;
  assign w_unused = ^{I_MEM_HBURST, I_MEM_HTRANS[0], w_off[1:0]};
`else
  assign w_bad = 1'b0;
  logic w_unused;
  assign w_unused = ^{I_MEM_HBURST, I_MEM_HTRANS[0], w_off[1:0], w_off[31:AW+2]};
`endif

  // state register and data-phase capture
  always_ff @(posedge I_MEM_HCLK or negedge I_MEM_HRESET_N) begin
    if (!I_MEM_HRESET_N) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_grant    <= 1'b0;
      r_wr_cnt   <= 16'd0;
      r_word     <= '0;
      r_lane     <= 2'b00;
      r_size     <= 3'b000;
      r_write    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_grant <= I_MEM_HBUSREQ;
      if (w_accept) begin
        r_wait_cnt <= WAIT_LOAD;
        r_word     <= w_off[AW+1:2];
        r_lane     <= I_MEM_HADDR[1:0];
        r_size     <= I_MEM_HSIZE;
        r_write    <= I_MEM_HWRITE;
      end else if ((r_state == S_WAIT) && (r_wait_cnt != 4'd0)) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      if (w_we && (r_wr_cnt != 16'hFFFF))
        r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE, S_LAST, S_ERR2: begin
        if (w_accept) begin
          if (w_bad)                w_next = S_ERR1;
          else if (WAIT_CYCLES > 0) w_next = S_WAIT;
          else                      w_next = S_LAST;
        end
      end
      S_WAIT:  w_next = (r_wait_cnt == 4'd0) ? S_LAST : S_WAIT;
      S_ERR1:  w_next = S_ERR2;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    O_MEM_HREADY = 1'b1;
    O_MEM_HRESP  = 2'b00;
    O_MEM_HRDATA = 32'h0;
    case (r_state)
      S_WAIT: O_MEM_HREADY = 1'b0;
      S_LAST: if (!r_write) O_MEM_HRDATA = r_mem[r_word];
`ifdef AHB_MEM_ERR_EN
      S_ERR1: begin
        O_MEM_HREADY = 1'b0;
        O_MEM_HRESP  = 2'b01;
      end
      S_ERR2: O_MEM_HRESP = 2'b01;
`endif
      default: ;
    endcase
  end

  // little-endian lanes; oversize accesses (when not rejected) write the whole word
  always_comb begin
    case (r_size)
      3'b000:  w_be = 4'b0001 << r_lane;
      3'b001:  w_be = r_lane[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  assign w_mask    = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
  assign w_we      = (r_state == S_LAST) & r_write;
  assign w_wmerged = (r_mem[r_word] & ~w_mask) | (I_MEM_HWDATA & w_mask);

  always_ff @(posedge I_MEM_HCLK) begin
    if (w_we) r_mem[r_word] <= w_wmerged;
  end

  assign O_MEM_HGRANT = r_grant;
  assign O_MEM_WR_CNT = r_wr_cnt;

endmodule

// File: tb/tb_ahb_img_mem.sv
// Bench for ahb_img_mem: two instances (0 and 1 wait states) driven by a pipelined AHB master
// and checked against an array-based reference memory.
module tb_ahb_img_mem;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busreq = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0]  htrans = '0;
  logic [2:0]  hsize = '0, hburst = '0;
  logic        hwrite = 1'b0;
  int          sel = 1;

  always #5 clk = ~clk;

  logic [1:0]  trans0, trans1, resp0, resp1, resp;
  logic        g0, g1, rdy0, rdy1, grant, rdy;
  logic [31:0] rd0, rd1, rdata;
  logic [15:0] wc0, wc1, wrcnt;

  assign trans0 = (sel == 0) ? htrans : 2'b00;
  assign trans1 = (sel == 1) ? htrans : 2'b00;
  assign grant  = (sel == 0) ? g0   : g1;
  assign rdy    = (sel == 0) ? rdy0 : rdy1;
  assign resp   = (sel == 0) ? resp0 : resp1;
  assign rdata  = (sel == 0) ? rd0  : rd1;
  assign wrcnt  = (sel == 0) ? wc0  : wc1;

  ahb_img_mem #(.DEPTH(DEPTH), .BASE(BASE), .WAIT_CYCLES(0)) u_dut0 (
    .I_MEM_HCLK(clk), .I_MEM_HRESET_N(rst_n), .I_MEM_HBUSREQ(busreq), .I_MEM_HADDR(haddr),
    .I_MEM_HTRANS(trans0), .I_MEM_HSIZE(hsize), .I_MEM_HBURST(hburst), .I_MEM_HWRITE(hwrite),
    .I_MEM_HWDATA(hwdata), .O_MEM_HGRANT(g0), .O_MEM_HREADY(rdy0), .O_MEM_HRESP(resp0),
    .O_MEM_HRDATA(rd0), .O_MEM_WR_CNT(wc0));

  ahb_img_mem #(.DEPTH(DEPTH), .BASE(BASE), .WAIT_CYCLES(1)) u_dut1 (
    .I_MEM_HCLK(clk), .I_MEM_HRESET_N(rst_n), .I_MEM_HBUSREQ(busreq), .I_MEM_HADDR(haddr),
    .I_MEM_HTRANS(trans1), .I_MEM_HSIZE(hsize), .I_MEM_HBURST(hburst), .I_MEM_HWRITE(hwrite),
    .I_MEM_HWDATA(hwdata), .O_MEM_HGRANT(g1), .O_MEM_HREADY(rdy1), .O_MEM_HRESP(resp1),
    .O_MEM_HRDATA(rd1), .O_MEM_WR_CNT(wc1));

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp;
  } xfer_t;

  typedef struct {
    int    dut;
    bit    flush;
    xfer_t x;
  } vec_t;

  xfer_t       q[$];
  logic [31:0] mdl [2][DEPTH];
  int          mcnt [2];
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (dut%0d t=%0t): got %h, expected %h", name, sel, $time, act, exp);
    end
  endtask

  function automatic xfer_t mk(input logic [1:0] t, input logic w, input logic [31:0] a,
                               input logic [2:0] s, input logic [31:0] d,
                               input bit c, input logic [31:0] e);
    xfer_t x;
    x.trans = t; x.wr = w; x.addr = a; x.size = s; x.wdata = d; x.chk = c; x.exp = e;
    return x;
  endfunction

  function automatic bit is_bad(input logic [31:0] a, input logic [2:0] s);
`ifdef AHB_MEM_ERR_EN
    logic [31:0] off;
    off = a - BASE;
    return (off >= 32'(4 * DEPTH)) || (s == 3'd1 && a[0]) ||
           (s == 3'd2 && a[1:0] != 2'b00) || (s > 3'd2);
`else
    return (a[0] & ~a[0]) | (s[0] & ~s[0]);
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off / 4) % DEPTH);
  endfunction

  function automatic void mdl_write(input int d, input logic [31:0] a, input logic [2:0] s,
                                    input logic [31:0] wd);
    int first, n, i;
    logic [31:0] w;
    if (s == 3'd0)      begin first = int'(a[1:0]);      n = 1; end
    else if (s == 3'd1) begin first = 2 * int'(a[1]);    n = 2; end
    else                begin first = 0;                 n = 4; end
    i = widx(a);
    w = mdl[d][i];
    for (int l = first; l < first + n; l++) w[8*l +: 8] = wd[8*l +: 8];
    mdl[d][i] = w;
    if (mcnt[d] < 65535) mcnt[d]++;
  endfunction

  task automatic drive_addr(input int k);
    if (k < q.size()) begin
      haddr = q[k].addr; htrans = q[k].trans; hwrite = q[k].wr; hsize = q[k].size;
      hburst = (q[k].trans == 2'b11) ? 3'b011 : 3'b000;
    end else begin
      haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b000; hburst = 3'b000;
    end
  endtask

  task automatic complete(input xfer_t x, input int waits);
    bit bad;
    int exp_w;
    logic [31:0] exp_d;
    bad   = is_bad(x.addr, x.size);
    exp_w = bad ? 1 : sel;
    chk("wait_states", 32'(waits), 32'(exp_w));
    if (x.wr) begin
      chk("rdata_on_write", rdata, 32'h0);
      if (!bad) mdl_write(sel, x.addr, x.size, x.wdata);
    end else begin
      exp_d = bad ? 32'h0 : (x.chk ? x.exp : mdl[sel][widx(x.addr)]);
      chk("rdata", rdata, exp_d);
    end
  endtask

  // Call 1 time unit after a rising edge; returns at the same phase with the bus idle.
  task automatic run_q();
    int ai, di, waits, budget;
    bit hr;
    ai = 0; di = -1; waits = 0; budget = 0;
    drive_addr(0);
    while ((ai < q.size() || di >= 0) && budget < 20000) begin
      @(negedge clk);
      budget++;
      chk("wr_cnt", 32'(wrcnt), 32'(mcnt[sel]));
      if (di >= 0) begin
        chk("hresp", 32'(resp), is_bad(q[di].addr, q[di].size) ? 32'h1 : 32'h0);
        if (!rdy) begin
          waits++;
          chk("rdata_during_wait", rdata, 32'h0);
        end else begin
          complete(q[di], waits);
        end
      end else begin
        chk("hready_idle", 32'(rdy), 32'h1);
        chk("rdata_idle", rdata, 32'h0);
      end
      hr = rdy;
      @(posedge clk); #1;
      if (hr) begin
        if (ai < q.size()) begin
          di = q[ai].trans[1] ? ai : -1;
          ai++;
        end else begin
          di = -1;
        end
        waits = 0;
        drive_addr(ai);
        hwdata = (di >= 0 && q[di].wr) ? q[di].wdata : 32'h0;
      end
    end
    if (budget >= 20000) chk("run_q_timeout", 32'(budget), 32'h0);
    q.delete();
  endtask

  vec_t dir[$];

  task automatic add(input int d, input bit f, input xfer_t x);
    vec_t v;
    v.dut = d; v.flush = f; v.x = x;
    dir.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  s;
    logic [1:0]  t;
    int          r;

    // directed vectors
    add(1, 0, mk(2'b10, 1, BASE + 32'h10, 3'd2, 32'hDEAD_BEEF, 0, 0));
    add(1, 1, mk(2'b10, 0, BASE + 32'h10, 3'd2, 32'h0,         1, 32'hDEAD_BEEF));
    add(1, 0, mk(2'b10, 1, BASE + 32'h20, 3'd2, 32'h0000_0000, 0, 0));
    add(1, 0, mk(2'b10, 1, BASE + 32'h21, 3'd0, 32'h0000_AA00, 0, 0));
    add(1, 0, mk(2'b10, 1, BASE + 32'h22, 3'd1, 32'h1234_0000, 0, 0));
    add(1, 1, mk(2'b10, 0, BASE + 32'h20, 3'd2, 32'h0,         1, 32'h1234_AA00));
    add(0, 0, mk(2'b10, 1, BASE + 32'h40, 3'd2, 32'd1, 0, 0));
    add(0, 0, mk(2'b11, 1, BASE + 32'h44, 3'd2, 32'd2, 0, 0));
    add(0, 0, mk(2'b11, 1, BASE + 32'h48, 3'd2, 32'd3, 0, 0));
    add(0, 0, mk(2'b11, 1, BASE + 32'h4C, 3'd2, 32'd4, 0, 0));
    add(0, 0, mk(2'b10, 0, BASE + 32'h40, 3'd2, 32'h0, 1, 32'd1));
    add(0, 0, mk(2'b11, 0, BASE + 32'h44, 3'd2, 32'h0, 1, 32'd2));
    add(0, 0, mk(2'b11, 0, BASE + 32'h48, 3'd2, 32'h0, 1, 32'd3));
    add(0, 1, mk(2'b11, 0, BASE + 32'h4C, 3'd2, 32'h0, 1, 32'd4));
    add(1, 0, mk(2'b10, 1, BASE + 32'(4 * DEPTH), 3'd2, 32'hCAFE_0001, 0, 0));
`ifdef AHB_MEM_ERR_EN
    add(1, 0, mk(2'b10, 0, BASE, 3'd2, 32'h0, 0, 0));
`else
    add(1, 0, mk(2'b10, 0, BASE, 3'd2, 32'h0, 1, 32'hCAFE_0001));
`endif
    add(1, 0, mk(2'b01, 0, BASE + 32'h30, 3'd2, 32'h0, 0, 0));
    add(1, 0, mk(2'b10, 1, BASE + 32'h31, 3'd1, 32'hBBBB_5566, 0, 0));
    add(1, 0, mk(2'b00, 0, BASE + 32'h30, 3'd2, 32'h0, 0, 0));
    add(1, 0, mk(2'b10, 1, BASE + 32'h36, 3'd3, 32'h7788_99AA, 0, 0));
    add(1, 0, mk(2'b10, 0, BASE + 32'h30, 3'd2, 32'h0, 0, 0));
    add(1, 1, mk(2'b10, 0, BASE + 32'h34, 3'd3, 32'h0, 0, 0));

    // reset values
    #12;
    for (int d = 0; d < 2; d++) begin
      sel = d; #1;
      chk("rst_hready", 32'(rdy), 32'h1);
      chk("rst_hresp", 32'(resp), 32'h0);
      chk("rst_hrdata", rdata, 32'h0);
      chk("rst_wr_cnt", 32'(wrcnt), 32'h0);
      chk("rst_hgrant", 32'(grant), 32'h0);
    end
    sel = 1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // grant follows request by one cycle
    for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end
    busreq = 1'b1;
    @(negedge clk); chk("grant_before_rise", 32'(grant), 32'h0);
    @(posedge clk); #1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk); chk("grant_held", 32'(grant), 32'h1);
      @(posedge clk); #1;
    end
    busreq = 1'b0;
    @(negedge clk); chk("grant_before_fall", 32'(grant), 32'h1);
    @(posedge clk); #1;
    @(negedge clk); chk("grant_after_fall", 32'(grant), 32'h0);
    @(posedge clk); #1;

    // fill both memories so every later read has a known reference value
    for (int d = 0; d < 2; d++) begin
      sel = d;
      for (int i = 0; i < DEPTH; i++)
        q.push_back(mk(2'b10, 1, BASE + 32'(4 * i), 3'd2, $urandom, 0, 0));
      run_q();
    end

    for (int i = 0; i < dir.size(); i++) begin
      sel = dir[i].dut;
      q.push_back(dir[i].x);
      if (dir[i].flush || i == dir.size() - 1) run_q();
    end

    // randomized traffic
    for (int d = 0; d < 2; d++) begin
      sel = d;
      for (int i = 0; i < 80; i++) begin
        r = int'($urandom_range(0, 99));
        t = (r < 8) ? 2'b00 : (r < 12) ? 2'b01 : (r < 55) ? 2'b10 : 2'b11;
        r = int'($urandom_range(0, 99));
        if (r < 80)      a = BASE + $urandom_range(0, 4 * DEPTH - 1);
        else if (r < 94) a = BASE + 32'(4 * DEPTH) + $urandom_range(0, 4 * DEPTH - 1);
        else             a = BASE - $urandom_range(1, 64);
        s = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        if ($urandom_range(0, 9) < 7) begin
          if (s == 3'd1) a[0] = 1'b0;
          if (s >= 3'd2) a[1:0] = 2'b00;
        end
        q.push_back(mk(t, 1'($urandom_range(0, 1)), a, s, $urandom, 0, 0));
      end
      run_q();
    end

    // asynchronous reset during the wait state of a write
    sel = 1;
    q.push_back(mk(2'b10, 1, BASE + 32'h80, 3'd2, 32'h5, 0, 0));
    run_q();
    busreq = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    haddr = BASE + 32'h80; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = 32'h99;
    @(negedge clk);
    chk("pre_reset_wait", 32'(rdy), 32'h0);
    chk("pre_reset_grant", 32'(grant), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_hready", 32'(rdy), 32'h1);
    chk("reset_hgrant", 32'(grant), 32'h0);
    chk("reset_hresp", 32'(resp), 32'h0);
    chk("reset_wr_cnt", 32'(wrcnt), 32'h0);
    mcnt[0] = 0; mcnt[1] = 0;
    busreq = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    q.push_back(mk(2'b10, 0, BASE + 32'h80, 3'd2, 32'h0, 1, 32'h5));
    run_q();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
